// File: rtl/read_bus_arbiter_pkg.sv
// rtl/read_bus_arbiter_pkg.sv - shared widths, state codes and grant codes for the read bus arbiter
// Contents:
//   BUS_WIDTH    default address/data width of the core read buses
//   rba_state_t  IDLE / ADDR / DATA transaction states (2-bit codes)
//   rba_grant_t  which requester owns the current transaction
package read_bus_arbiter_pkg;

  localparam int BUS_WIDTH = 32;

  typedef enum logic [1:0] {
    RBA_IDLE = 2'd0,
    RBA_ADDR = 2'd1,
    RBA_DATA = 2'd2
  } rba_state_t;

  typedef enum logic {
    RBA_GRANT_IR = 1'b0,
    RBA_GRANT_DR = 1'b1
  } rba_grant_t;

endpackage

// File: rtl/read_bus_arbiter_rr_arbiter_2.sv
// rtl/read_bus_arbiter_rr_arbiter_2.sv - two-way round-robin arbiter, purely combinational
// Ports:
//   req         in   2  request bits, [0]=ir, [1]=dr
//   last_grant  in   1  requester that won the previous arbitration
//   gnt         out  2  one-hot grant, all zero when nobody requests
module rr_arbiter_2
  import read_bus_arbiter_pkg::*;
(
  input  logic [1:0]  req,
  input  rba_grant_t  last_grant,
  output logic [1:0]  gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // Contention: whoever did not win last time goes now.
      2'b11:   gnt = (last_grant == RBA_GRANT_IR) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/read_bus_arbiter.sv
// rtl/read_bus_arbiter.sv - merges instruction and data read channels onto one memory read port
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   ir_addr_valid/ir_addr/ir_addr_ready    instruction request channel
//   ir_data_valid/ir_data/ir_data_ready    instruction response channel
//   dr_*                           same as ir_*, data side
//   m_addr_valid/m_addr/m_addr_ready       request to memory (registered)
//   m_data_valid/m_data/m_data_ready       response from memory
//   timeout_err                    sticky, response not seen within timeout_cycles
//   ir_grant_count/dr_grant_count  wrapping grant counters
module read_bus_arbiter
  import read_bus_arbiter_pkg::*;
#(
  parameter int addr_width     = BUS_WIDTH,
  parameter int data_width     = BUS_WIDTH,
  parameter int timeout_cycles = 1024,
  parameter int count_width    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ir_addr_valid,
  input  logic [addr_width-1:0]  ir_addr,
  output logic                   ir_addr_ready,
  output logic                   ir_data_valid,
  output logic [data_width-1:0]  ir_data,
  input  logic                   ir_data_ready,
  input  logic                   dr_addr_valid,
  input  logic [addr_width-1:0]  dr_addr,
  output logic                   dr_addr_ready,
  output logic                   dr_data_valid,
  output logic [data_width-1:0]  dr_data,
  input  logic                   dr_data_ready,
  output logic                   m_addr_valid,
  output logic [addr_width-1:0]  m_addr,
  input  logic                   m_addr_ready,
  input  logic                   m_data_valid,
  input  logic [data_width-1:0]  m_data,
  output logic                   m_data_ready,
  output logic                   timeout_err,
  output logic [count_width-1:0] ir_grant_count,
  output logic [count_width-1:0] dr_grant_count
);

  // Timer is wide enough to reach timeout_cycles-1 and saturates at all ones,
  // so a long stall after the flag is set never wraps back through the match.
  localparam int timer_width = $clog2(timeout_cycles + 2);
  localparam logic [timer_width-1:0] timer_last =
    timer_width'(timeout_cycles > 0 ? timeout_cycles - 1 : 0);
  localparam logic [timer_width-1:0] timer_max = '1;
  localparam bit timeout_en = (timeout_cycles > 0);

  rba_state_t             state;
  rba_grant_t             grant;
  rba_grant_t             last_grant;
  logic [1:0]             gnt;
  logic [timer_width-1:0] timer;
  logic                   data_hs;

  rr_arbiter_2 u_rr_arbiter_2 (
    .req        ({dr_addr_valid, ir_addr_valid}),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  // Address ready is only offered in IDLE, so the cycle that completes a
  // response (still DATA) can never accept the next request.
  assign ir_addr_ready = (state == RBA_IDLE) && gnt[0];
  assign dr_addr_ready = (state == RBA_IDLE) && gnt[1];

  // Response path: only the granted side sees memory, the other side reads 0.
  always_comb begin
    m_data_ready  = 1'b0;
    ir_data_valid = 1'b0;
    dr_data_valid = 1'b0;
    ir_data       = '0;
    dr_data       = '0;
    if (state == RBA_DATA) begin
      if (grant == RBA_GRANT_IR) begin
        m_data_ready  = ir_data_ready;
        ir_data_valid = m_data_valid;
        ir_data       = m_data;
      end else begin
        m_data_ready  = dr_data_ready;
        dr_data_valid = m_data_valid;
        dr_data       = m_data;
      end
    end
  end

  assign data_hs = m_data_valid && m_data_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= RBA_IDLE;
      grant          <= RBA_GRANT_DR;
      last_grant     <= RBA_GRANT_DR;
      m_addr         <= '0;
      m_addr_valid   <= 1'b0;
      timer          <= '0;
      timeout_err    <= 1'b0;
      ir_grant_count <= '0;
      dr_grant_count <= '0;
    end else begin
      case (state)
        RBA_IDLE: begin
          if (gnt[0]) begin
            m_addr         <= ir_addr;
            grant          <= RBA_GRANT_IR;
            last_grant     <= RBA_GRANT_IR;
            ir_grant_count <= ir_grant_count + count_width'(1);
            m_addr_valid   <= 1'b1;
            state          <= RBA_ADDR;
          end else if (gnt[1]) begin
            m_addr         <= dr_addr;
            grant          <= RBA_GRANT_DR;
            last_grant     <= RBA_GRANT_DR;
            dr_grant_count <= dr_grant_count + count_width'(1);
            m_addr_valid   <= 1'b1;
            state          <= RBA_ADDR;
          end
        end
        RBA_ADDR: begin
          if (m_addr_ready) begin
            m_addr_valid <= 1'b0;
            timer        <= '0;
            state        <= RBA_DATA;
          end
        end
        RBA_DATA: begin
          if (data_hs) begin
            state <= RBA_IDLE;
          end else begin
            if (timer != timer_max) begin
              timer <= timer + timer_width'(1);
            end
            // Flag only; the transaction keeps waiting for memory.
            if (timeout_en && (timer == timer_last)) begin
              timeout_err <= 1'b1;
            end
          end
        end
        default: begin
          state        <= RBA_IDLE;
          m_addr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
